// File: rtl/prefetcher_read_responder_if.sv
// AXI read-channel bundle between the prefetcher (master) and the DRAM-side responder (slave).
// Carries the AR request fields and the R beat fields.
interface prefetcher_read_responder_if #(
    parameter int ADDR_BITS = 64,
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 4,
    parameter int LEN_BITS  = 8
) ();
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_BITS-1:0] ar_addr;
    logic [LEN_BITS-1:0]  ar_len;
    logic [ID_BITS-1:0]   ar_id;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_last;
    logic [ID_BITS-1:0]   r_id;
    logic [1:0]           r_resp;

    modport master (
        output ar_valid, ar_addr, ar_len, ar_id, r_ready,
        input  ar_ready, r_valid, r_data, r_last, r_id, r_resp
    );

    modport slave (
        input  ar_valid, ar_addr, ar_len, ar_id, r_ready,
        output ar_ready, r_valid, r_data, r_last, r_id, r_resp
    );
endinterface

// File: rtl/prefetcher_read_responder.sv
// AXI read-slave stand-in for DRAM: queues AR requests and returns INCR bursts whose beat
// data is the beat address replicated across the data word, after a programmable latency.
module prefetcher_read_responder #(
    parameter int LOG_FIFO_DEPTH       = 3,
    parameter int LOG_BLOCK_DATA_BYTES = 6,
    parameter int ADDR_BITS            = 64,
    parameter int ID_BITS              = 4,
    parameter int LEN_BITS             = 8,
    parameter int LAT_BITS             = 8
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic [LAT_BITS-1:0]           crs_latency,
    prefetcher_read_responder_if.slave    axi,
    output logic                          busy
);
    localparam int DEPTH     = 1 << LOG_FIFO_DEPTH;
    localparam int DATA_BITS = 8 << LOG_BLOCK_DATA_BYTES;
    localparam int REPS      = DATA_BITS / ADDR_BITS;
    localparam logic [LOG_FIFO_DEPTH:0] FULL_COUNT = (LOG_FIFO_DEPTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    function automatic logic [DATA_BITS-1:0] replicateAddr(input logic [ADDR_BITS-1:0] a);
        replicateAddr = {REPS{a}};
    endfunction

    logic [ADDR_BITS-1:0]    addrMem_r [DEPTH];
    logic [LEN_BITS-1:0]     lenMem_r  [DEPTH];
    logic [ID_BITS-1:0]      idMem_r   [DEPTH];
    logic [LOG_FIFO_DEPTH-1:0] wrPtr_r, rdPtr_r;
    logic [LOG_FIFO_DEPTH:0] count_r, nextCount_s;
    logic                    full_r;

    state_t                  state_r;
    logic [ADDR_BITS-1:0]    addr_r, nextBeatAddr_s;
    logic [LEN_BITS-1:0]     len_r, beatCnt_r;
    logic [ID_BITS-1:0]      id_r;
    logic [LAT_BITS-1:0]     latCnt_r;
    logic                    rValid_r, rLast_r, busy_r;
    logic [DATA_BITS-1:0]    rData_r;
    logic [ID_BITS-1:0]      rId_r;

    logic                    pushEn_s, popEn_s, lastHs_s, nextIdle_s;
    logic [ADDR_BITS-1:0]    headAddr_s;
    logic [LEN_BITS-1:0]     headLen_s;
    logic [ID_BITS-1:0]      headId_s;

    // Handshake decode, FIFO occupancy and next-beat address
    always_comb begin
        pushEn_s   = axi.ar_valid && !full_r;
        popEn_s    = (state_r == IDLE) && (count_r != '0);
        lastHs_s   = rValid_r && axi.r_ready && (beatCnt_r == len_r);
        headAddr_s = addrMem_r[rdPtr_r];
        headLen_s  = lenMem_r[rdPtr_r];
        headId_s   = idMem_r[rdPtr_r];
        nextBeatAddr_s = addr_r + ((ADDR_BITS'(beatCnt_r) + ADDR_BITS'(1'b1)) << LOG_BLOCK_DATA_BYTES);
        if (pushEn_s && !popEn_s) begin
            nextCount_s = count_r + (LOG_FIFO_DEPTH+1)'(1'b1);
        end else if (!pushEn_s && popEn_s) begin
            nextCount_s = count_r - (LOG_FIFO_DEPTH+1)'(1'b1);
        end else begin
            nextCount_s = count_r;
        end
        nextIdle_s = ((state_r == IDLE) && !popEn_s) || ((state_r == BURST) && lastHs_s);
    end

    // Request storage; entries are only meaningful between the pointers, so no reset needed
    always_ff @(posedge clk) begin
        if (pushEn_s) begin
            addrMem_r[wrPtr_r] <= axi.ar_addr;
            lenMem_r[wrPtr_r]  <= axi.ar_len;
            idMem_r[wrPtr_r]   <= axi.ar_id;
        end
    end

    // FIFO pointers, count, registered full flag and busy
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
            full_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            if (pushEn_s) begin
                wrPtr_r <= wrPtr_r + LOG_FIFO_DEPTH'(1'b1);
            end
            if (popEn_s) begin
                rdPtr_r <= rdPtr_r + LOG_FIFO_DEPTH'(1'b1);
            end
            count_r <= nextCount_s;
            full_r  <= (nextCount_s == FULL_COUNT);
            busy_r  <= !nextIdle_s || (nextCount_s != '0);
        end
    end

    // Burst FSM with registered R outputs; outputs are zero whenever no beat is offered
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r   <= IDLE;
            addr_r    <= '0;
            len_r     <= '0;
            id_r      <= '0;
            beatCnt_r <= '0;
            latCnt_r  <= '0;
            rValid_r  <= 1'b0;
            rData_r   <= '0;
            rLast_r   <= 1'b0;
            rId_r     <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (popEn_s) begin
                        addr_r    <= headAddr_s;
                        len_r     <= headLen_s;
                        id_r      <= headId_s;
                        beatCnt_r <= '0;
                        latCnt_r  <= crs_latency;
                        if (crs_latency == '0) begin
                            state_r  <= BURST;
                            rValid_r <= 1'b1;
                            rData_r  <= replicateAddr(headAddr_s);
                            rLast_r  <= (headLen_s == '0);
                            rId_r    <= headId_s;
                        end else begin
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    latCnt_r <= latCnt_r - LAT_BITS'(1'b1);
                    if (latCnt_r == LAT_BITS'(1'b1)) begin
                        state_r  <= BURST;
                        rValid_r <= 1'b1;
                        rData_r  <= replicateAddr(addr_r);
                        rLast_r  <= (len_r == '0);
                        rId_r    <= id_r;
                    end
                end
                BURST: begin
                    if (rValid_r && axi.r_ready) begin
                        if (beatCnt_r == len_r) begin
                            state_r  <= IDLE;
                            rValid_r <= 1'b0;
                            rData_r  <= '0;
                            rLast_r  <= 1'b0;
                            rId_r    <= '0;
                        end else begin
                            beatCnt_r <= beatCnt_r + LEN_BITS'(1'b1);
                            rData_r   <= replicateAddr(nextBeatAddr_s);
                            rLast_r   <= ((beatCnt_r + LEN_BITS'(1'b1)) == len_r);
                        end
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    rValid_r <= 1'b0;
                    rData_r  <= '0;
                    rLast_r  <= 1'b0;
                    rId_r    <= '0;
                end
            endcase
        end
    end

    assign axi.ar_ready = !full_r;
    assign axi.r_valid  = rValid_r;
    assign axi.r_data   = rData_r;
    assign axi.r_last   = rLast_r;
    assign axi.r_id     = rId_r;
    assign axi.r_resp   = 2'b00;
    assign busy         = busy_r;
endmodule

// File: tb/tb_prefetcher_read_responder.sv
// Directed bench for prefetcher_read_responder: expected beats are queued at AR acceptance
// and compared against every R handshake; timing is checked from recorded cycle numbers.
module tb_prefetcher_read_responder;
    typedef struct packed {
        logic [63:0] addr;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic       clk;
    logic       resetN;
    logic [7:0] crs_latency;
    logic       busy;

    prefetcher_read_responder_if #(.ADDR_BITS(64), .DATA_BITS(512), .ID_BITS(4), .LEN_BITS(8)) axi ();

    prefetcher_read_responder #(
        .LOG_FIFO_DEPTH(3), .LOG_BLOCK_DATA_BYTES(6), .ADDR_BITS(64),
        .ID_BITS(4), .LEN_BITS(8), .LAT_BITS(8)
    ) dut (
        .clk(clk), .resetN(resetN), .crs_latency(crs_latency), .axi(axi), .busy(busy)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int hsCount = 0;
    beat_t sbQ[$];
    int startQ[$];
    int endQ[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearRecords();
        startQ.delete();
        endQ.delete();
        hsCount = 0;
    endtask

    task automatic pushAr(input logic [63:0] a, input logic [7:0] l, input logic [3:0] id,
                          input int maxWait, output bit accepted, output int hsCyc);
        accepted = 1'b0;
        hsCyc = -1;
        axi.ar_valid = 1'b1;
        axi.ar_addr = a;
        axi.ar_len = l;
        axi.ar_id = id;
        for (int i = 0; i < maxWait; i++) begin
            @(negedge clk);
            if (axi.ar_ready) begin
                @(posedge clk);
                #1;
                accepted = 1'b1;
                hsCyc = cyc;
                for (int b = 0; b <= int'(l); b++) begin
                    sbQ.push_back('{addr: a + (64'(b) << 6), last: (b == int'(l)), id: id});
                end
                break;
            end
        end
        axi.ar_valid = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, output int idleCyc);
        bit seen;
        seen = 1'b0;
        idleCyc = -1;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (!busy) begin
                idleCyc = cyc;
                seen = 1'b1;
                break;
            end
        end
        check("idleTimeout", seen, 1'b1);
    endtask

    // R-channel monitor: scoreboard compare, stall stability and idle-zero checks
    initial begin
        logic         prevValid;
        logic         prevStall;
        logic [511:0] prevData;
        logic         prevLast;
        logic [3:0]   prevId;
        beat_t        e;
        prevValid = 1'b0;
        prevStall = 1'b0;
        prevData = '0;
        prevLast = 1'b0;
        prevId = '0;
        forever begin
            @(negedge clk);
            if (resetN) begin
                if (prevStall) begin
                    check("stallValid", axi.r_valid, 1'b1);
                    check("stallData", axi.r_data, prevData);
                    check("stallCtl", {axi.r_last, axi.r_id}, {prevLast, prevId});
                end
                if (axi.r_valid) begin
                    if (!prevValid) startQ.push_back(cyc);
                    if (axi.r_ready) begin
                        hsCount++;
                        check("beatExpected", sbQ.size() != 0, 1'b1);
                        if (sbQ.size() != 0) begin
                            e = sbQ.pop_front();
                            check("beatData", axi.r_data, {8{e.addr}});
                            check("beatLast", axi.r_last, e.last);
                            check("beatId", axi.r_id, e.id);
                            check("beatResp", axi.r_resp, 2'b00);
                            if (e.last) endQ.push_back(cyc);
                        end
                    end
                end else begin
                    check("idleData", axi.r_data, '0);
                    check("idleCtl", {axi.r_last, axi.r_id}, 5'd0);
                end
                prevValid = axi.r_valid;
                prevStall = axi.r_valid && !axi.r_ready;
                prevData = axi.r_data;
                prevLast = axi.r_last;
                prevId = axi.r_id;
            end else begin
                prevValid = 1'b0;
                prevStall = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        int arCyc, c, idleCyc;

        resetN = 1'b0;
        crs_latency = 8'd0;
        axi.ar_valid = 1'b0;
        axi.ar_addr = 64'd0;
        axi.ar_len = 8'd0;
        axi.ar_id = 4'd0;
        axi.r_ready = 1'b0;
        #3;
        check("rstArReady", axi.ar_ready, 1'b1);
        check("rstRValid", axi.r_valid, 1'b0);
        check("rstBusy", busy, 1'b0);
        check("rstRData", axi.r_data, '0);
        check("rstRCtl", {axi.r_last, axi.r_id, axi.r_resp}, 7'd0);
        repeat (2) @(posedge clk);
        #1 resetN = 1'b1;

        // single burst, zero latency
        step();
        clearRecords();
        axi.r_ready = 1'b1;
        pushAr(64'h1000, 8'd3, 4'd5, 4, acc, arCyc);
        check("t1Accept", acc, 1'b1);
        waitIdle(50, idleCyc);
        check("t1FirstValid", startQ.size() > 0 ? startQ[0] : -1, arCyc + 1);
        check("t1LastBeat", endQ.size() > 0 ? endQ[0] : -1, arCyc + 4);
        check("t1BusyFall", idleCyc, arCyc + 5);
        check("t1Beats", hsCount, 4);

        // latency 4, back-to-back requests, ordering and bubble spacing
        step();
        clearRecords();
        crs_latency = 8'd4;
        pushAr(64'h2000, 8'd0, 4'd1, 4, acc, arCyc);
        pushAr(64'h3000, 8'd1, 4'd2, 4, acc, c);
        pushAr(64'h4000, 8'd0, 4'd3, 4, acc, c);
        waitIdle(100, idleCyc);
        check("t2Bursts", {startQ.size(), endQ.size()}, {32'd3, 32'd3});
        if (startQ.size() == 3 && endQ.size() == 3) begin
            check("t2Start0", startQ[0], arCyc + 5);
            check("t2End0", endQ[0], startQ[0]);
            check("t2Start1", startQ[1], endQ[0] + 6);
            check("t2End1", endQ[1], startQ[1] + 1);
            check("t2Start2", startQ[2], endQ[1] + 6);
        end
        check("t2Beats", hsCount, 4);

        // backpressure with pseudo-random r_ready
        step();
        clearRecords();
        crs_latency = 8'd2;
        axi.r_ready = 1'b0;
        pushAr(64'h8000, 8'd7, 4'd7, 4, acc, c);
        for (int i = 0; i < 300; i++) begin
            step();
            axi.r_ready = 1'($urandom_range(0, 1));
            if (!busy) break;
        end
        axi.r_ready = 1'b1;
        check("t3Done", busy, 1'b0);
        check("t3Beats", hsCount, 8);
        check("t3Drained", sbQ.size(), 0);

        // FIFO full with consumer stalled
        step();
        clearRecords();
        crs_latency = 8'd0;
        axi.r_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pushAr(64'h10000 + 64'(i) * 64'h1000, 8'd0, 4'(i), (i == 9) ? 4 : 3, acc, c);
            if (i < 9) check("t4Accept", acc, 1'b1);
            else check("t4Stall", acc, 1'b0);
            if (i == 8) begin
                @(negedge clk);
                check("t4Full", axi.ar_ready, 1'b0);
            end
        end
        step();
        axi.r_ready = 1'b1;
        waitIdle(100, idleCyc);
        check("t4Beats", hsCount, 9);
        check("t4BusyFall", idleCyc, endQ.size() > 0 ? endQ[endQ.size()-1] + 1 : -1);
        check("t4ArReady", axi.ar_ready, 1'b1);

        // address wrap
        step();
        clearRecords();
        crs_latency = 8'd1;
        pushAr(64'hFFFF_FFFF_FFFF_FFC0, 8'd1, 4'hE, 4, acc, c);
        waitIdle(50, idleCyc);
        check("t5Beats", hsCount, 2);

        // asynchronous reset in the middle of a burst with requests queued
        step();
        clearRecords();
        crs_latency = 8'd0;
        axi.r_ready = 1'b0;
        pushAr(64'h20000, 8'd7, 4'hA, 4, acc, c);
        pushAr(64'h21000, 8'd1, 4'hB, 4, acc, c);
        pushAr(64'h22000, 8'd1, 4'hC, 4, acc, c);
        step();
        axi.r_ready = 1'b1;
        step();
        step();
        check("t6BeatIndex", hsCount, 2);
        #1 resetN = 1'b0;
        #1;
        check("t6RstValid", axi.r_valid, 1'b0);
        check("t6RstArReady", axi.ar_ready, 1'b1);
        check("t6RstBusy", busy, 1'b0);
        sbQ.delete();
        repeat (2) step();
        resetN = 1'b1;
        step();
        clearRecords();
        pushAr(64'h30000, 8'd1, 4'd9, 4, acc, c);
        check("t6Accept", acc, 1'b1);
        waitIdle(50, idleCyc);
        check("t6Beats", hsCount, 2);
        check("t6Drained", sbQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
